// File: rtl/vasip_pkg.sv
// Shared types and sizing for the vector load path.
package vasip_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int DEPTH     = 1024;
    localparam int LANES     = 4;
    localparam int MAX_ELEMS = 16;
    localparam int VREG_W    = 4;
    localparam int CNT_W     = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } vload_state_t;

    // Requests longer than the vector are truncated to a full vector.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        if (c > CNT_W'(MAX_ELEMS)) begin
            return CNT_W'(MAX_ELEMS);
        end
        return c;
    endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// Lane address generator: four running lane addresses advanced by 4*stride
// each beat, plus per-lane active and out-of-range flags.
module vec_addr_gen
    import vasip_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init,
    input  logic                    step,
    input  logic [ADDR_W-1:0]       base,
    input  logic [ADDR_W-1:0]       stride,
    input  logic [CNT_W-1:0]        n,
    output logic [LANES*ADDR_W-1:0] lane_addr,
    output logic [LANES-1:0]        active,
    output logic [LANES-1:0]        oor,
    output logic [CNT_W-1:0]        elem,
    output logic                    last_beat
);

    logic signed [ADDR_W-1:0] stride_s;
    logic signed [ADDR_W-1:0] stride4_q;
    addr_t                    lane_q [LANES];
    logic [CNT_W-1:0]         elem_q;

    assign stride_s = signed'(stride);
    assign elem     = elem_q;

    // Seed lanes with base + j*stride using shifts/adds, then step by 4*stride per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < LANES; j++) begin
                lane_q[j] <= '0;
            end
            stride4_q <= '0;
            elem_q    <= '0;
        end else if (init) begin
            lane_q[0] <= base;
            lane_q[1] <= base + addr_t'(stride_s);
            lane_q[2] <= base + addr_t'(stride_s <<< 1);
            lane_q[3] <= base + addr_t'(stride_s <<< 1) + addr_t'(stride_s);
            stride4_q <= stride_s <<< 2;
            elem_q    <= '0;
        end else if (step) begin
            for (int j = 0; j < LANES; j++) begin
                lane_q[j] <= lane_q[j] + addr_t'(stride4_q);
            end
            elem_q <= elem_q + CNT_W'(LANES);
        end
    end

    // Lane is active while its element index is below n; range flag is unsigned compare.
    always_comb begin
        lane_addr = '0;
        active    = '0;
        oor       = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_addr[j*ADDR_W +: ADDR_W] = lane_q[j];
            active[j] = ({1'b0, elem_q} + (CNT_W+1)'(j)) < {1'b0, n};
            oor[j]    = lane_q[j] >= ADDR_W'(DEPTH);
        end
        last_beat = ({1'b0, elem_q} + (CNT_W+1)'(LANES)) >= {1'b0, n};
    end

endmodule

// File: rtl/vec_load_unit.sv
// Strided vector load: fetches up to MAX_ELEMS words, four per cycle, from the
// 4-port dmem and writes the packed vector to the VRF in one cycle.
module vec_load_unit
    import vasip_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base,
    input  logic [ADDR_W-1:0]           stride,
    input  logic [CNT_W-1:0]            count,
    input  logic [VREG_W-1:0]           vd,
    output logic                        busy,
    output logic                        done,
    output logic                        addr_err,
    output logic [ADDR_W-1:0]           addr1,
    output logic [ADDR_W-1:0]           addr2,
    output logic [ADDR_W-1:0]           addr3,
    output logic [ADDR_W-1:0]           addr4,
    input  logic [DATA_W-1:0]           out1,
    input  logic [DATA_W-1:0]           out2,
    input  logic [DATA_W-1:0]           out3,
    input  logic [DATA_W-1:0]           out4,
    output logic                        vrf_we,
    output logic [VREG_W-1:0]           vrf_waddr,
    output logic [MAX_ELEMS*DATA_W-1:0] vrf_wdata
);

    vload_state_t                  state_q;
    vload_state_t                  state_d;
    logic [CNT_W-1:0]              n_q;
    logic [VREG_W-1:0]             vd_q;
    logic                          err_q;
    logic [MAX_ELEMS*DATA_W-1:0]   buf_q;

    logic                          accept;
    logic                          in_load;
    logic [LANES*ADDR_W-1:0]       lane_addr;
    logic [LANES-1:0]              active;
    logic [LANES-1:0]              oor;
    logic [CNT_W-1:0]              elem;
    logic                          last_beat;
    word_t                         lane_data [LANES];
    logic [3:0]                    elem_idx  [LANES];

    assign accept  = (state_q == IDLE) && start;
    assign in_load = (state_q == LOAD);

    assign lane_data[0] = out1;
    assign lane_data[1] = out2;
    assign lane_data[2] = out3;
    assign lane_data[3] = out4;

    vec_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .init      (accept),
        .step      (in_load),
        .base      (base),
        .stride    (stride),
        .n         (n_q),
        .lane_addr (lane_addr),
        .active    (active),
        .oor       (oor),
        .elem      (elem),
        .last_beat (last_beat)
    );

    // Buffer slot for each lane this beat; only active lanes (always < MAX_ELEMS) write.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            elem_idx[j] = 4'(elem + CNT_W'(j));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a zero-length request skips LOAD and goes straight to WRITE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (clamp_count(count) == '0) ? WRITE : LOAD;
            LOAD:    if (last_beat) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: addresses only driven during LOAD; write strobe suppressed for n=0.
    always_comb begin
        busy      = (state_q == LOAD) || (state_q == WRITE);
        done      = (state_q == WRITE);
        vrf_we    = (state_q == WRITE) && (n_q != '0);
        addr_err  = (state_q == WRITE) && err_q;
        vrf_waddr = vd_q;
        vrf_wdata = buf_q;
        addr1     = in_load ? lane_addr[0*ADDR_W +: ADDR_W] : '0;
        addr2     = in_load ? lane_addr[1*ADDR_W +: ADDR_W] : '0;
        addr3     = in_load ? lane_addr[2*ADDR_W +: ADDR_W] : '0;
        addr4     = in_load ? lane_addr[3*ADDR_W +: ADDR_W] : '0;
    end

    // Request latch and packing buffer: dmem data is captured the same cycle it is addressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q   <= '0;
            vd_q  <= '0;
            err_q <= 1'b0;
            buf_q <= '0;
        end else if (accept) begin
            n_q   <= clamp_count(count);
            vd_q  <= vd;
            err_q <= 1'b0;
            buf_q <= '0;
        end else if (in_load) begin
            for (int j = 0; j < LANES; j++) begin
                if (active[j]) begin
                    buf_q[DATA_W*elem_idx[j] +: DATA_W] <= lane_data[j];
                end
            end
            err_q <= err_q | (|(active & oor));
        end
    end

endmodule

// File: tb/tb_vec_load_unit.sv
// Bench for vec_load_unit: directed table, multi-cycle corner sequences and
// randomized loads checked against a behavioural model of the load.
module tb_vec_load_unit;
    import vasip_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  base;
    logic [31:0]  stride;
    logic [4:0]   count;
    logic [3:0]   vd;
    logic         busy, done, addr_err, vrf_we;
    logic [31:0]  addr1, addr2, addr3, addr4;
    logic [31:0]  out1, out2, out3, out4;
    logic [3:0]   vrf_waddr;
    logic [511:0] vrf_wdata;

    vec_load_unit dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .stride(stride),
        .count(count), .vd(vd), .busy(busy), .done(done), .addr_err(addr_err),
        .addr1(addr1), .addr2(addr2), .addr3(addr3), .addr4(addr4),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a < 32'(DEPTH)) return mem[a[9:0]];
        return 32'hBAD00000 ^ a;
    endfunction

    assign out1 = rd(addr1);
    assign out2 = rd(addr2);
    assign out3 = rd(addr3);
    assign out4 = rd(addr4);

    int checks = 0;
    int passed = 0;
    logic [511:0] last_w;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: element i of the vector is dmem[base + i*stride] for i < min(count,16).
    task automatic model(input logic [31:0] b, input logic [31:0] s, input logic [4:0] c,
                         output logic [511:0] w, output int lat, output logic we,
                         output logic err);
        int n;
        logic [31:0] a;
        n   = (int'(c) > MAX_ELEMS) ? MAX_ELEMS : int'(c);
        w   = '0;
        err = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = b + 32'(i) * s;
            w[i*32 +: 32] = rd(a);
            if (a >= 32'(DEPTH)) err = 1'b1;
        end
        lat = (n + 3) / 4 + 1;
        we  = (n > 0);
    endtask

    task automatic run_load(input logic [31:0] b, input logic [31:0] s, input logic [4:0] c,
                            input logic [3:0] v, input int exp_lat, input logic exp_we,
                            input logic exp_err);
        logic [511:0] mw;
        int           mlat;
        logic         mwe, merr;
        int           n, beats, lat, g;
        logic [127:0] exp_a;
        model(b, s, c, mw, mlat, mwe, merr);
        n     = (int'(c) > MAX_ELEMS) ? MAX_ELEMS : int'(c);
        beats = (n + 3) / 4;
        g = 0;
        while (busy && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("idle_addr", 512'({addr1, addr2, addr3, addr4}), 512'(0));
        base = b; stride = s; count = c; vd = v; start = 1'b1;
        @(posedge clk);
        lat = 99;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                chk("busy_after_accept", 512'(busy), 512'(1));
            end
            if (cyc <= beats) begin
                for (int j = 0; j < 4; j++) begin
                    exp_a[(3-j)*32 +: 32] = b + 32'(4*(cyc-1) + j) * s;
                end
                chk("beat_addrs", 512'({addr1, addr2, addr3, addr4}), 512'(exp_a));
            end
            if (done) begin
                lat = cyc;
                break;
            end
        end
        chk("latency", 512'(lat), 512'(exp_lat));
        chk("vrf_we", 512'(vrf_we), 512'(exp_we));
        chk("addr_err", 512'(addr_err), 512'(exp_err));
        chk("vrf_waddr", 512'(vrf_waddr), 512'(v));
        chk("vrf_wdata", vrf_wdata, mw);
        last_w = vrf_wdata;
    endtask

    typedef struct {
        logic [31:0] b;
        logic [31:0] s;
        logic [4:0]  c;
        logic [3:0]  v;
        int          lat;
        logic        we;
        logic        err;
    } vec_t;

    vec_t tab [7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone, nwe;
        logic [511:0] rw;
        int rl;
        logic rwe, rerr;
        logic [31:0] rb, rs;

        tab[0] = '{32'd0,        32'd1,          5'd16, 4'd3,  5, 1'b1, 1'b0};
        tab[1] = '{32'd10,       32'd3,          5'd6,  4'd5,  3, 1'b1, 1'b0};
        tab[2] = '{32'd20,       32'hFFFFFFFE,   5'd4,  4'd7,  2, 1'b1, 1'b0};
        tab[3] = '{32'd1020,     32'd1,          5'd8,  4'd2,  3, 1'b1, 1'b1};
        tab[4] = '{32'd0,        32'd5,          5'd0,  4'd9,  1, 1'b0, 1'b0};
        tab[5] = '{32'd7,        32'd1,          5'd31, 4'd1,  5, 1'b1, 1'b0};
        tab[6] = '{32'd100,      32'd0,          5'd5,  4'd15, 3, 1'b1, 1'b0};

        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i) + 32'h100;

        rst = 1'b1; start = 1'b0; base = '0; stride = '0; count = '0; vd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_we", 512'(vrf_we), 512'(0));
        chk("rst_err", 512'(addr_err), 512'(0));
        chk("rst_waddr", 512'(vrf_waddr), 512'(0));
        chk("rst_wdata", vrf_wdata, 512'(0));
        chk("rst_addrs", 512'({addr1, addr2, addr3, addr4}), 512'(0));
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_load(tab[i].b, tab[i].s, tab[i].c, tab[i].v, tab[i].lat, tab[i].we, tab[i].err);
            if (i == 0) begin
                chk("elem0", 512'(last_w[31:0]), 512'(32'h100));
                chk("elem15", 512'(last_w[511:480]), 512'(32'h10F));
            end
            if (i == 1) chk("tail_zero", 512'(last_w[511:192]), 512'(0));
            if (i == 2) chk("neg_stride_e3", 512'(last_w[127:96]), 512'(32'h100 + 32'd14));
        end

        // Reset during beat 2 of a 16-element load aborts without a VRF write.
        @(negedge clk);
        base = 0; stride = 1; count = 16; vd = 4; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_we", 512'(vrf_we), 512'(0));
        rst = 1'b0;
        nwe = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (vrf_we || done) nwe++;
        end
        chk("abort_no_write", 512'(nwe), 512'(0));

        // start held through LOAD and WRITE is ignored; only one done results.
        base = 0; stride = 2; count = 8; vd = 6; start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            if (done) ndone++;
            if (cyc == 4) chk("idle_after_done", 512'(busy), 512'(0));
            start = (cyc <= 3);
        end
        chk("single_done", 512'(ndone), 512'(1));

        // Randomized loads against the model, with random dmem contents.
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int t = 0; t < 40; t++) begin
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1100));
            case ($urandom_range(0, 3))
                0:       rs = 32'd0;
                1:       rs = 32'($urandom_range(0, 10)) - 32'd5;
                2:       rs = 32'($urandom);
                default: rs = 32'd1;
            endcase
            count = 5'($urandom_range(0, 31));
            model(rb, rs, count, rw, rl, rwe, rerr);
            run_load(rb, rs, count, 4'($urandom_range(0, 15)), rl, rwe, rerr);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vec_load_unit.md
Name: vec_load_unit

Overview:
- Strided vector-load engine that sits directly upstream of the 4-port data memory.
- Generates four element addresses per cycle into dmem's addr1..addr4 and captures its combinational out1..out4 data.
- Packs up to MAX_ELEMS 32-bit elements into one vector.
- Writes the packed vector to the vector register file in a single write cycle, with a start/busy/done handshake to the control unit.

Parameters:
- LANES, 4, elements fetched per cycle; fixed to the dmem read-port count.
- MAX_ELEMS, 16, maximum vector length in elements (multiple of LANES).
- DATA_W, 32, element width.
- ADDR_W, 32, address width.
- DEPTH, 1024, dmem word count; used for range checking.
- VREG_W, 4, vector register index width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a load; accepted only in IDLE.
- base  in  ADDR_W  word address of element 0.
- stride  in  ADDR_W  signed word stride between elements.
- count  in  5  number of elements; clamped to MAX_ELEMS.
- vd  in  VREG_W  destination vector register.
- busy  out  1  high in LOAD and WRITE.
- done  out  1  one-cycle pulse at completion.
- addr_err  out  1  valid with done; any active element address was >= DEPTH.
- addr1..addr4  out  ADDR_W each  element addresses to dmem lanes 0..3.
- out1..out4  in  DATA_W each  read data from dmem lanes 0..3.
- vrf_we  out  1  vector register write enable.
- vrf_waddr  out  VREG_W  write index (latched vd).
- vrf_wdata  out  MAX_ELEMS*DATA_W  packed vector; element i occupies bits [32i+31:32i].

Behaviour:
- **Reset** (rst=1 at clk edge):
  - state=IDLE.
  - busy, done, addr_err, vrf_we = 0.
  - addr1..4, vrf_waddr = 0; element buffer and vrf_wdata = 0.
  - Reset mid-operation aborts the load; no VRF write occurs.
- **States:** IDLE, LOAD, WRITE.
- **IDLE:**
  - addr1..4 driven 0.
  - On start=1: latch base, stride, clamped count, vd; clear buffer, beat counter and error flag.
  - If clamped count=0: go directly to WRITE, which then performs no write (vrf_we=0, done=1).
  - Otherwise go to LOAD.
- **LOAD, beat k** (k = 0..ceil(n/4)-1):
  - Lane j address = base + (4k+j)*stride, modulo 2^32 with signed stride.
  - Computed incrementally: lane start value base + j*stride; each beat adds 4*stride. No multiplier.
  - dmem read is combinational, so out1..out4 are captured at the end of the same cycle into elements 4k..4k+3.
  - Lanes whose element index >= n capture 0 and do not contribute to addr_err; their addresses are still driven.
  - addr_err is set if any active lane address >= DEPTH. Out-of-range addresses are still driven unmodified.
  - After the last beat, go to WRITE.
- **WRITE:**
  - vrf_we=1 (n>0), vrf_waddr=vd, vrf_wdata=buffer, done=1, addr_err valid.
  - Next state IDLE.
  - Elements n..MAX_ELEMS-1 of vrf_wdata are 0.
- **Timing:**
  - Latency from the start-accept edge to done = ceil(n/4)+1 cycles.
  - busy=1 throughout LOAD and WRITE.
- start while busy is ignored, not queued. start in the WRITE cycle is ignored.
- A new start is accepted on the first IDLE cycle after done, giving back-to-back loads with one idle cycle.
- Stride 0 is legal: all lanes read the same word.

Decomposition:
- Shared package vasip_pkg holds:
  - DATA_W, ADDR_W, DEPTH, LANES, MAX_ELEMS, VREG_W.
  - typedef word_t (logic [DATA_W-1:0]).
  - typedef addr_t.
  - enum vload_state_t {IDLE, LOAD, WRITE}.
- One natural sub-module: vec_addr_gen, containing the four lane address registers, the stride*4 increment, and the per-lane active/range flags.
- The FSM and packing buffer stay in vec_load_unit.

Test Plan:
- dmem[i]=i+0x100; start base=0, stride=1, count=16, vd=3:
  - addr1..4=0,1,2,3 then 4..7, 8..11, 12..15;
  - done in the 5th cycle after accept;
  - vrf_wdata elements = 0x100..0x10F, vrf_waddr=3, addr_err=0.
- base=10, stride=3, count=6:
  - beat 0 addrs 10,13,16,19; beat 1 addrs 22,25,28,31;
  - elements 6..15 = 0; done at cycle 3.
- base=20, stride=-2 (0xFFFFFFFE), count=4: addrs 20,18,16,14; correct data packed; addr_err=0.
- base=1020, stride=1, count=8: lanes reach 1024..1027, so addr_err=1 with done and vrf_we=1.
- count=0: done=1 one cycle after accept, vrf_we=0. count=31: clamped to 16, 4 beats.
- rst asserted during beat 2 of a 16-element load:
  - busy=0 next cycle, no vrf_we.
  - start pulses while busy produce no extra done.
